vec_store_image: RTL and testbench

//  Write-back stage downstream of the 8-lane pixel vector load/ALU path.

---
 rtl/cpu_vec_pkg.sv | 25 ++
 rtl/image_out_ram.sv | 39 +++
 rtl/vec_store_image.sv | 142 ++++++++++++++
 tb/tb_vec_store_image.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_vec_pkg.sv
// Shared types and the pixel saturation helper for the vector store path.
package cpu_vec_pkg;

    localparam int LANES    = 8;
    localparam int PIX_SIZE = 8;
    localparam int VEC_W    = 16;

    typedef logic [15:0][VEC_W-1:0] vec_t;

    typedef enum logic {S_IDLE, S_WRITE} vst_state_t;

    localparam logic [PIX_SIZE-1:0] PIX_MAX = '1;

    // Clamp one 16-bit lane into the stored pixel range.
    function automatic logic [PIX_SIZE-1:0] sat_pix(input logic [VEC_W-1:0] v, input bit signed_mode);
        if (signed_mode && v[VEC_W-1]) begin
            return '0;
        end
        if (v > VEC_W'(PIX_MAX)) begin
            return PIX_MAX;
        end
        return v[PIX_SIZE-1:0];
    endfunction

endpackage

// File: rtl/image_out_ram.sv
// Output image byte store: one write port, one registered read port.
// Reads return the pre-write byte on a same-address collision; out-of-range reads return 0.
module image_out_ram #(
    parameter int DEPTH = 9216,
    parameter int AW    = 14,
    parameter int DW    = 8
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [15:0]   raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    // Contents survive reset on purpose; only the read register is cleared.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            rdata_q <= '0;
        end else if (raddr_i < 16'(DEPTH)) begin
            rdata_q <= mem_q[raddr_i[AW-1:0]];
        end else begin
            rdata_q <= '0;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/vec_store_image.sv
// Vector write-back: saturates up to LANES lanes and writes them one byte per cycle into the image RAM,
// tracking pixel count, completion and out-of-range addresses.
module vec_store_image
    import cpu_vec_pkg::*;
#(
    parameter int IMAGE_WIDTH  = 96,
    parameter int IMAGE_HEIGHT = 96,
    parameter int PIX_SIZE     = cpu_vec_pkg::PIX_SIZE,
    parameter int LANES        = cpu_vec_pkg::LANES,
    parameter int SAT_SIGNED   = 1
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                VALID,
    output logic                READY,
    input  logic [15:0]         Addr,
    input  vec_t                WD,
    input  logic                Clear,
    input  logic [15:0]         RdAddr,
    output logic [PIX_SIZE-1:0] RdData,
    output logic                Busy,
    output logic [15:0]         PixCount,
    output logic                Done,
    output logic                Oob
);

    localparam int NPIX = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam int AW   = $clog2(NPIX);
    localparam int CW   = $clog2(LANES);

    vst_state_t                     state_q;
    logic                           ready_q;
    logic                           busy_q;
    logic [CW-1:0]                  cnt_q;
    logic [15:0]                    base_q;
    logic [LANES-1:0][PIX_SIZE-1:0] lanes_q;
    logic [LANES-1:0][PIX_SIZE-1:0] lanes_sat;

    logic [15:0] pix_q, pix_d, pix_base;
    logic        done_q, done_d;
    logic        oob_q, oob_d;

    logic [16:0] wr_addr;
    logic        in_range;
    logic        wr_en;
    logic        unused_wd;

    assign unused_wd = ^WD[15:LANES];

    always_comb begin
        lanes_sat = '0;
        for (int i = 0; i < LANES; i++) begin
            lanes_sat[i] = sat_pix(WD[i], SAT_SIGNED != 0);
        end
    end

    // 17-bit sum so a base near 16'hFFFF cannot wrap back into the image.
    assign wr_addr  = {1'b0, base_q} + 17'(cnt_q);
    assign in_range = wr_addr < 17'(NPIX);
    assign wr_en    = (state_q == S_WRITE) && in_range;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            base_q  <= '0;
            lanes_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (VALID) begin
                        base_q  <= Addr;
                        lanes_q <= lanes_sat;
                        cnt_q   <= '0;
                        state_q <= S_WRITE;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                S_WRITE: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(LANES - 1)) begin
                        state_q <= S_IDLE;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Clear is applied first, then the same-cycle write is counted on top of it.
    always_comb begin
        pix_base = Clear ? 16'd0 : pix_q;
        pix_d    = pix_base;
        if (wr_en && pix_base != 16'hFFFF) begin
            pix_d = pix_base + 16'd1;
        end
        done_d = (Clear ? 1'b0 : done_q) | (wr_en && pix_d == 16'(NPIX));
        oob_d  = (Clear ? 1'b0 : oob_q) | ((state_q == S_WRITE) && !in_range);
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            pix_q  <= '0;
            done_q <= 1'b0;
            oob_q  <= 1'b0;
        end else begin
            pix_q  <= pix_d;
            done_q <= done_d;
            oob_q  <= oob_d;
        end
    end

    image_out_ram #(
        .DEPTH (NPIX),
        .AW    (AW),
        .DW    (PIX_SIZE)
    ) u_ram (
        .clk_i   (CLK),
        .rst_n_i (RST_N),
        .we_i    (wr_en && RST_N),
        .waddr_i (wr_addr[AW-1:0]),
        .wdata_i (lanes_q[cnt_q]),
        .raddr_i (RdAddr),
        .rdata_o (RdData)
    );

    assign READY    = ready_q;
    assign Busy     = busy_q;
    assign PixCount = pix_q;
    assign Done     = done_q;
    assign Oob      = oob_q;

endmodule

// File: tb/tb_vec_store_image.sv
// Directed bench for vec_store_image: timing, saturation, bounds, completion, reset abort, collisions.
module tb_vec_store_image;
    import cpu_vec_pkg::*;

    logic        CLK;
    logic        RST_N;
    logic        VALID;
    logic        READY;
    logic [15:0] Addr;
    vec_t        WD;
    logic        Clear;
    logic [15:0] RdAddr;
    logic [7:0]  RdData;
    logic        Busy;
    logic [15:0] PixCount;
    logic        Done;
    logic        Oob;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    vec_store_image dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .VALID    (VALID),
        .READY    (READY),
        .Addr     (Addr),
        .WD       (WD),
        .Clear    (Clear),
        .RdAddr   (RdAddr),
        .RdData   (RdData),
        .Busy     (Busy),
        .PixCount (PixCount),
        .Done     (Done),
        .Oob      (Oob)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for READY, presents one vector, returns the cycle index of the accepting edge.
    task automatic send_vec(input logic [15:0] a, input vec_t w, output int k);
        int n;
        n = 0;
        @(negedge CLK);
        while (!READY && n < 50) begin
            @(negedge CLK);
            n++;
        end
        chk("accept_ready", {31'd0, READY}, 32'd1);
        VALID = 1'b1;
        Addr  = a;
        WD    = w;
        @(posedge CLK);
        #1;
        k     = cyc;
        VALID = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, output logic [7:0] d);
        @(negedge CLK);
        RdAddr = a;
        @(negedge CLK);
        d = RdData;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge CLK);
        while (!READY && n < 50) begin
            @(negedge CLK);
            n++;
        end
        chk("idle_ready", {31'd0, READY}, 32'd1);
    endtask

    initial begin
        vec_t       w;
        int         k, k0, kl;
        logic [7:0] d;
        logic [7:0] exp2 [8];

        RST_N  = 1'b0;
        VALID  = 1'b0;
        Clear  = 1'b0;
        Addr   = '0;
        WD     = '0;
        RdAddr = '0;
        repeat (3) @(negedge CLK);
        chk("rst_ready", {31'd0, READY}, 32'd1);
        chk("rst_busy",  {31'd0, Busy}, 32'd0);
        chk("rst_pix",   {16'd0, PixCount}, 32'd0);
        chk("rst_done",  {31'd0, Done}, 32'd0);
        chk("rst_oob",   {31'd0, Oob}, 32'd0);
        chk("rst_rd",    {24'd0, RdData}, 32'd0);
        RST_N = 1'b1;

        // Basic burst: READY low for 8 cycles after the accept edge.
        w = '0;
        for (int i = 0; i < 8; i++) w[i] = 16'(i);
        send_vec(16'd0, w, k);
        for (int j = 0; j < 8; j++) begin
            @(negedge CLK);
            chk($sformatf("t1_ready_low%0d", j), {31'd0, READY}, 32'd0);
            chk($sformatf("t1_busy%0d", j), {31'd0, Busy}, 32'd1);
        end
        @(negedge CLK);
        chk("t1_ready_back", {31'd0, READY}, 32'd1);
        chk("t1_busy_done",  {31'd0, Busy}, 32'd0);
        chk("t1_pix",        {16'd0, PixCount}, 32'd8);
        for (int i = 0; i < 8; i++) begin
            rd(16'(i), d);
            chk($sformatf("t1_ram%0d", i), {24'd0, d}, i);
        end

        // Signed saturation.
        w = '0;
        w[0] = 16'hFFFB; w[1] = 16'd300;   w[2] = 16'd255; w[3] = 16'd256;
        w[4] = 16'h8000; w[5] = 16'h7FFF;  w[6] = 16'd0;   w[7] = 16'd128;
        w[9] = 16'd77;
        exp2 = '{8'd0, 8'd255, 8'd255, 8'd255, 8'd0, 8'd255, 8'd0, 8'd128};
        send_vec(16'd16, w, k);
        wait_idle();
        chk("t2_pix", {16'd0, PixCount}, 32'd16);
        for (int i = 0; i < 8; i++) begin
            rd(16'(16 + i), d);
            chk($sformatf("t2_sat%0d", i), {24'd0, d}, {24'd0, exp2[i]});
        end

        // Straddling the image end: two lanes dropped.
        w = '0;
        for (int i = 0; i < 8; i++) w[i] = 16'(10 + i);
        send_vec(16'd9210, w, k);
        wait_idle();
        chk("t3_pix",  {16'd0, PixCount}, 32'd22);
        chk("t3_oob",  {31'd0, Oob}, 32'd1);
        chk("t3_done", {31'd0, Done}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            rd(16'(9210 + i), d);
            chk($sformatf("t3_ram%0d", 9210 + i), {24'd0, d}, 10 + i);
        end
        rd(16'd9216, d);
        chk("t3_rd_oor", {24'd0, d}, 32'd0);

        // Clear, then fill the whole image back-to-back.
        @(negedge CLK);
        Clear = 1'b1;
        @(negedge CLK);
        Clear = 1'b0;
        chk("t4_clr_pix", {16'd0, PixCount}, 32'd0);
        chk("t4_clr_oob", {31'd0, Oob}, 32'd0);
        k0 = 0;
        kl = 0;
        for (int v = 0; v < 1152; v++) begin
            w = '0;
            for (int i = 0; i < 8; i++) w[i] = 16'((v * 8 + i) & 255);
            send_vec(16'(v * 8), w, k);
            if (v == 0) k0 = k;
            kl = k;
        end
        chk("t4_span", kl - k0, 32'(1151 * 9));
        repeat (8) @(negedge CLK);
        chk("t4_done_pre", {31'd0, Done}, 32'd0);
        chk("t4_pix_pre",  {16'd0, PixCount}, 32'd9215);
        @(negedge CLK);
        chk("t4_done", {31'd0, Done}, 32'd1);
        chk("t4_pix",  {16'd0, PixCount}, 32'd9216);
        chk("t4_oob",  {31'd0, Oob}, 32'd0);
        rd(16'd5000, d);
        chk("t4_ram5000", {24'd0, d}, 32'd136);

        // Reset lands on the lane-3 write edge.
        w = '0;
        for (int i = 0; i < 8; i++) w[i] = 16'(16'hA0 + i);
        send_vec(16'd100, w, k);
        repeat (4) @(negedge CLK);
        RST_N = 1'b0;
        @(negedge CLK);
        chk("t5_ready", {31'd0, READY}, 32'd1);
        chk("t5_busy",  {31'd0, Busy}, 32'd0);
        chk("t5_pix",   {16'd0, PixCount}, 32'd0);
        chk("t5_done",  {31'd0, Done}, 32'd0);
        chk("t5_oob",   {31'd0, Oob}, 32'd0);
        chk("t5_rd",    {24'd0, RdData}, 32'd0);
        RST_N = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rd(16'(100 + i), d);
            chk($sformatf("t5_ram%0d", 100 + i), {24'd0, d}, (i < 3) ? 32'(8'hA0 + i) : 32'(100 + i));
        end

        // Clear colliding with a write, and read-before-write on the same address.
        w = '0;
        send_vec(16'd300, w, k);
        wait_idle();
        chk("t6_pix_pre", {16'd0, PixCount}, 32'd8);
        for (int i = 0; i < 8; i++) w[i] = 16'(16'h50 + i);
        send_vec(16'd200, w, k);
        @(negedge CLK);
        Clear  = 1'b1;
        RdAddr = 16'd200;
        @(negedge CLK);
        chk("t6_rbw", {24'd0, RdData}, 32'd200);
        chk("t6_clr_pix", {16'd0, PixCount}, 32'd1);
        Clear = 1'b0;
        wait_idle();
        chk("t6_pix_end", {16'd0, PixCount}, 32'd8);
        rd(16'd200, d);
        chk("t6_ram200", {24'd0, d}, 32'h50);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
